mac_pipe_ctrl: RTL
==================

# mac_pipe_ctrl

Sequencing controller for the team's pipelined multiply-accumulate datapath, whose stage registers are plain clocked D-flip-flop banks (8-bit operands through a 30-bit accumulator). The block generates per-stage load enables, tracks valid/frame tags alongside the data, drives accumulator first/accumulate/result-load strobes, and applies valid/ready backpressure at both ends. It contains no datapath bits; it sits beside the register banks and owns every enable they see.

## Interface
- STAGES, 4, pipeline register stages between the input capture and the accumulator; legal range 2..8
- LEN_W, 8, width of the frame-length field

- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  controller accepts a sample this cycle
- cfg_len  in  LEN_W  samples per accumulation frame; 0 is treated as 1
- stage_en  out  STAGES  load enable for datapath stage i
- acc_en  out  1  accumulator register update this cycle
- acc_first  out  1  with acc_en: load the accumulator with the product instead of adding it
- out_load  out  1  result register captures the final accumulator sum
- out_valid  in/out: out  1  result register holds an unconsumed frame result
- out_ready  in  1  downstream accepts the result
- busy  out  1  any beat in flight, partial frame counted, or result pending

## Operation
- Accept: in_valid & in_ready. stage_en[0] = accept.
- Beat counter cnt (LEN_W bits): 0 after reset. On accept: if cnt == 0, latch len = (cfg_len == 0 ? 1 : cfg_len); tag first = (cnt == 0), last = (cnt == len-1), where len is the latched or newly latched value. cnt increments on accept and returns to 0 after the last beat. cfg_len is ignored mid-frame.
- Valid/tag pipe: v[i], first[i], last[i] for i = 0..STAGES-1. On accept, v[0] is set; otherwise v[0] clears when stage 1 advances. Stage i (i ≥ 1) loads from stage i-1 when not stalled.
- stall = v[STAGES-1] & last[STAGES-1] & out_valid & ~out_ready. This is the only stall source and freezes the whole pipe.
- in_ready = ~stall; forced 0 while rstn is low.
- stage_en[i] = v[i-1] & ~stall for i ≥ 1.
- acc_en = v[STAGES-1] & ~stall; acc_first = acc_en & first[STAGES-1]; out_load = acc_en & last[STAGES-1]. A single-beat frame asserts acc_first and out_load together, and the result equals that product.
- out_valid: set on out_load; cleared on out_ready when out_load is low; stays 1 if out_load and out_ready occur in the same cycle, meaning the new result replaces the consumed one.
- Bubbles (v = 0) propagate without asserting acc_en; non-last beats never stall even when a result is pending.
- busy = |v | (cnt != 0) | out_valid.

## Timing
- All state is reset to 0 asynchronously: cnt, len, v, first, last, out_valid. Outputs during and after reset: in_ready 0 while rstn is low and 1 after release; all other outputs 0.
- Latency without stall: accept in cycle 0 → v[0] in cycle 1 → v[STAGES-1] plus acc_en in cycle STAGES → out_valid in cycle STAGES+1.
- Throughput is 1 beat/cycle sustained when out_ready is held high.
- Stall takes effect combinationally in the same cycle; no beat is lost or duplicated, and all tags hold.
- Reset asserted mid-frame discards all in-flight beats and any pending result. The first accept after release starts a new frame with a freshly latched len.

## Test plan
- Reset: hold rstn low for 3 cycles with in_valid=1 → in_ready=0 and all strobes 0; after release, in_ready=1 and busy=0.
- STAGES=4, cfg_len=3, 3 back-to-back beats, out_ready=1 → acc_en in cycles 4,5,6; acc_first only in 4; out_load in 6; out_valid in 7 only.
- cfg_len=0, one beat → acc_first and out_load both high in cycle 4; out_valid=1 in cycle 5.
- cfg_len=2, 4 continuous beats, out_ready=0 until cycle 10 → second last-beat holds at stage 3 with in_ready=0 from cycle 7 to 9; out_ready=1 in cycle 10 gives out_load and out_valid stays 1; no beat is dropped.
- Change cfg_len from 4 to 2 after the first beat of a frame → the frame still completes after 4 beats; the next frame uses 2.
- Drop rstn during beat 2 of a 5-beat frame → all v and out_valid cleared; after release, the first beat carries acc_first.

Source files
------------

// File: rtl/mac_pipe_ctrl.sv
// Sequencing controller for the pipelined MAC datapath: stage load enables,
// valid/first/last tag pipe, accumulator strobes and result backpressure.

module mac_tag_stage (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [2:0] d,
  output logic [2:0] q
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   q <= '0;
    else if (en) q <= d;
  end
endmodule

module mac_pipe_ctrl #(
  parameter int STAGES = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic [STAGES-1:0] stage_en,
  output logic              acc_en,
  output logic              acc_first,
  output logic              out_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  // Index 0 is the beat being accepted this cycle; index i+1 is register stage i.
  logic [STAGES:0]  vld_pipe, first_pipe, last_pipe;
  logic             stall, accept, beat_last;
  logic [LEN_W-1:0] cnt, len, len_new, len_cur;

  // Only a finished frame blocked by an unconsumed result can stall.
  assign stall     = vld_pipe[STAGES] & last_pipe[STAGES] & out_valid & ~out_ready;
  assign in_ready  = rstn & ~stall;
  assign accept    = in_valid & in_ready;

  assign len_new   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign len_cur   = (cnt == '0) ? len_new : len;
  assign beat_last = (cnt == len_cur - LEN_W'(1));

  assign vld_pipe[0]   = accept;
  assign first_pipe[0] = (cnt == '0);
  assign last_pipe[0]  = beat_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      len <= '0;
    end else if (accept) begin
      if (cnt == '0) len <= len_new;
      cnt <= beat_last ? '0 : cnt + LEN_W'(1);
    end
  end

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      mac_tag_stage u_stage (
        .clk  (clk),
        .rstn (rstn),
        .en   (~stall),
        .d    ({vld_pipe[i],   first_pipe[i],   last_pipe[i]}),
        .q    ({vld_pipe[i+1], first_pipe[i+1], last_pipe[i+1]})
      );
      assign stage_en[i] = vld_pipe[i] & ~stall;
    end
  endgenerate

  assign acc_en    = vld_pipe[STAGES] & ~stall;
  assign acc_first = acc_en & first_pipe[STAGES];
  assign out_load  = acc_en & last_pipe[STAGES];

  // A load in the same cycle as a consume keeps the flag set for the new result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          out_valid <= 1'b0;
    else if (out_load)  out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  assign busy = (|vld_pipe[STAGES:1]) | (cnt != '0) | out_valid;

endmodule
